// File: rtl/fetch_prefetch_buffer.sv
// Sequential instruction prefetcher: issues one fetch per cycle to a synchronous ROM and queues {pc, instr}.
// Head is valid two edges after issue; issue stalls once queued plus in-flight entries reach DEPTH.
module fetch_prefetch_buffer #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic [ADDR_WIDTH-1:0] iaddr,
  input  logic [31:0]           idata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [31:0]           out_pc,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  logic [31:0] fetch_pc;
  logic [31:0] pending_pc;
  logic        pending;
  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;

  logic        issue;
  logic        push;
  logic        pop;
  logic [PW:0] inflight;
  logic        unused_rpc_bits;

  // Counting the in-flight request guarantees its data always has a free slot.
  assign inflight  = count + (PW+1)'(pending);
  assign issue     = !redirect && (inflight < FULL);
  assign push      = pending && !redirect;
  assign out_valid = (count != '0) && !redirect;
  assign pop       = out_valid && out_ready;

  assign iaddr     = fetch_pc[ADDR_WIDTH+1:2];
  assign out_pc    = fifo_pc[rd_ptr];
  assign out_instr = fifo_instr[rd_ptr];

  assign unused_rpc_bits = ^redirect_pc[1:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc   <= RESET_PC;
      pending    <= 1'b0;
      pending_pc <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect) begin
      // In-flight ROM data belongs to the old path and is dropped with the queue.
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      pending  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      pending <= issue;
      if (issue) begin
        pending_pc <= fetch_pc;
        fetch_pc   <= fetch_pc + 32'd4;
      end
      if (push) begin
        fifo_pc[wr_ptr]    <= pending_pc;
        fifo_instr[wr_ptr] <= idata;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: behavioural ROM plus a queue of expected {pc, instr} per fetch stream.
module tb_fetch_prefetch_buffer;

  localparam int          AW       = 10;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [AW-1:0] iaddr;
  logic [31:0]   idata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          redirect;
  logic [31:0]   redirect_pc;

  int total = 0;
  int bad   = 0;

  logic [63:0]   exp_q [$];
  logic [63:0]   e;
  logic          s_vld;
  logic [31:0]   s_pc;
  logic [31:0]   s_instr;
  logic [AW-1:0] s_iaddr;

  fetch_prefetch_buffer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RESET(RESET), .iaddr(iaddr), .idata(idata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: word k holds A000_0000 + k.
  always @(posedge CLK) idata <= 32'hA000_0000 + {{(32-AW){1'b0}}, iaddr};

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    logic [31:0] w;
    w = (pc >> 2) & ((32'd1 << AW) - 32'd1);
    return 32'hA000_0000 + w;
  endfunction

  task automatic expect_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    pc = {start[31:2], 2'b00};
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({pc, rom_word(pc)});
      pc = pc + 32'd4;
    end
  endtask

  // Samples outputs mid-cycle, then returns 1 time unit after the next rising edge.
  task automatic cycle();
    @(negedge CLK);
    s_vld   = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_iaddr = iaddr;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    expect_stream(RESET_PC, 128);
  endtask

  task automatic test_reset();
    RESET = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", out_instr); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", out_pc); end
    total++; if (iaddr !== RESET_PC[AW+1:2]) begin bad++; $display("FAIL reset_iaddr got=%h want=%h", iaddr, RESET_PC[AW+1:2]); end
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (s_vld !== (i == 2)) begin bad++; $display("FAIL release_latency cycle=%0d got=%b want=%b", i, s_vld, (i == 2)); end
    end
    total++; if (s_pc !== RESET_PC) begin bad++; $display("FAIL first_head_pc got=%h want=%h", s_pc, RESET_PC); end
  endtask

  task automatic test_stream();
    int acc = 0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i >= 2) begin
        total++; if (s_vld !== 1'b1) begin bad++; $display("FAIL stream_gap cycle=%0d got=%b want=1", i, s_vld); end
      end
      if (s_vld && out_ready) begin
        acc++; total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL stream_extra pc=%h", s_pc); end
        else begin
          e = exp_q.pop_front();
          if ({s_pc, s_instr} !== e) begin bad++; $display("FAIL stream_data got=%h/%h want=%h/%h", s_pc, s_instr, e[63:32], e[31:0]); end
        end
      end
    end
    total++; if (acc != 18) begin bad++; $display("FAIL stream_count got=%0d want=18", acc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i >= 2) begin
        total++;
        if ({s_vld, s_pc, s_instr} !== {1'b1, 32'h0, 32'hA000_0000}) begin
          bad++; $display("FAIL stall_head cycle=%0d got=%b/%h/%h want=1/0/a0000000", i, s_vld, s_pc, s_instr);
        end
      end
    end
    total++; if (s_iaddr !== AW'(4)) begin bad++; $display("FAIL stall_issue_stop iaddr got=%0d want=4", s_iaddr); end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      total++;
      if (!s_vld) begin bad++; $display("FAIL drain_gap cycle=%0d got=0 want=1", i); end
      else if (exp_q.size() == 0) begin bad++; $display("FAIL drain_extra pc=%h", s_pc); end
      else begin
        e = exp_q.pop_front();
        if ({s_pc, s_instr} !== e) begin bad++; $display("FAIL drain_data got=%h/%h want=%h/%h", s_pc, s_instr, e[63:32], e[31:0]); end
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (4) cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    cycle();
    total++; if (s_vld !== 1'b0) begin bad++; $display("FAIL redirect_valid1 got=%b want=0", s_vld); end
    redirect_pc = 32'h0000_0103;
    cycle();
    total++; if (s_vld !== 1'b0) begin bad++; $display("FAIL redirect_valid2 got=%b want=0", s_vld); end
    redirect = 1'b0;
    expect_stream(32'h0000_0103, 32);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i < 2) begin
        total++; if (s_vld !== 1'b0) begin bad++; $display("FAIL redirect_stale cycle=%0d got=%b/%h want=0", i, s_vld, s_pc); end
      end else if (s_vld && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL redirect_extra pc=%h", s_pc); end
        else begin
          e = exp_q.pop_front();
          if ({s_pc, s_instr} !== e) begin bad++; $display("FAIL redirect_data got=%h/%h want=%h/%h", s_pc, s_instr, e[63:32], e[31:0]); end
        end
      end else begin
        total++; bad++; $display("FAIL redirect_gap cycle=%0d got=0 want=1", i);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] want_ia [3];
    int acc = 0;
    want_ia[0] = AW'(10'h3FE); want_ia[1] = AW'(10'h3FF); want_ia[2] = AW'(0);
    do_reset();
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0FF8;
    cycle();
    redirect = 1'b0;
    expect_stream(32'h0000_0FF8, 16);
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i < 3) begin
        total++; if (s_iaddr !== want_ia[i]) begin bad++; $display("FAIL wrap_iaddr cycle=%0d got=%h want=%h", i, s_iaddr, want_ia[i]); end
      end
      if (s_vld && out_ready) begin
        acc++; total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL wrap_extra pc=%h", s_pc); end
        else begin
          e = exp_q.pop_front();
          if ({s_pc, s_instr} !== e) begin bad++; $display("FAIL wrap_data got=%h/%h want=%h/%h", s_pc, s_instr, e[63:32], e[31:0]); end
        end
      end
    end
    total++; if (acc != 8) begin bad++; $display("FAIL wrap_count got=%0d want=8", acc); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (3) cycle();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_async_valid got=%b want=1", out_valid); end
    #2;
    RESET = 1'b1;
    #1;
    total++;
    if ({out_valid, out_pc, out_instr} !== 65'h0) begin
      bad++; $display("FAIL async_reset_outputs got=%b/%h/%h want=0/0/0", out_valid, out_pc, out_instr);
    end
    total++; if (iaddr !== RESET_PC[AW+1:2]) begin bad++; $display("FAIL async_reset_iaddr got=%h want=%h", iaddr, RESET_PC[AW+1:2]); end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    expect_stream(RESET_PC, 16);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      total++;
      if (s_vld !== (i >= 2)) begin bad++; $display("FAIL async_restart_valid cycle=%0d got=%b want=%b", i, s_vld, (i >= 2)); end
      else if (s_vld) begin
        e = exp_q.pop_front();
        if ({s_pc, s_instr} !== e) begin bad++; $display("FAIL async_restart_data got=%h/%h want=%h/%h", s_pc, s_instr, e[63:32], e[31:0]); end
      end
    end
  endtask

  task automatic test_random();
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;
    logic [31:0] rpc;
    int acc = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 9) == 0) begin
        rpc = $urandom;
        redirect = 1'b1; redirect_pc = rpc;
        cycle();
        total++; if (s_vld !== 1'b0) begin bad++; $display("FAIL rand_redirect_valid cycle=%0d got=%b want=0", i, s_vld); end
        redirect = 1'b0;
        expect_stream(rpc, 600);
        prev_stall = 1'b0;
      end else begin
        cycle();
        if (prev_stall && s_vld) begin
          total++;
          if ({s_pc, s_instr} !== {prev_pc, prev_instr}) begin
            bad++; $display("FAIL rand_stall_stable got=%h/%h want=%h/%h", s_pc, s_instr, prev_pc, prev_instr);
          end
        end
        if (s_vld && out_ready) begin
          acc++; total++;
          if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra pc=%h", s_pc); end
          else begin
            e = exp_q.pop_front();
            if ({s_pc, s_instr} !== e) begin bad++; $display("FAIL rand_data got=%h/%h want=%h/%h", s_pc, s_instr, e[63:32], e[31:0]); end
          end
        end
        prev_stall = s_vld && !out_ready;
        prev_pc    = s_pc;
        prev_instr = s_instr;
      end
    end
    total++; if (acc < 100) begin bad++; $display("FAIL rand_throughput got=%0d want>=100", acc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
